// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO push arbiter: FSM encoding and stat counter helpers.
// The stat counters are only used when FIFO_PUSH_ARB_STATS_EN is defined.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int STAT_W = 16;

   // Saturating increment: sticks at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping from N-1 back to 0.
module rr_picker #(
   parameter int N   = 4,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           any,
   output logic [IDW-1:0] idx
);

   int               j;
   logic [IDW-1:0]   jj;

   // Scan from the farthest offset down so the nearest match wins.
   always_comb begin
      any = |req;
      idx = '0;
      j   = 0;
      jj  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j  = (int'(ptr) + k) % N;
         jj = IDW'(j);
         if (req[jj]) idx = jj;
      end
   end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin burst arbiter pushing one requester at a time into a FIFO.
// Define FIFO_PUSH_ARB_STATS_EN to add per-requester saturating beat counters.
module fifo_push_arb
   import fifo_arb_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DWIDTH = 8,
   parameter int BURST  = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_last,
   input  logic [NREQ*DWIDTH-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     fifo_not_full,
   output logic                     fifo_push,
   output logic [DWIDTH-1:0]        fifo_din,
   output logic [IDW-1:0]           grant_id,
   output logic                     busy
`ifdef FIFO_PUSH_ARB_STATS_EN
   ,
   output logic [NREQ*STAT_W-1:0]   stat_beats
`endif
);

   arb_state_t       state_reg;
   logic [IDW-1:0]   grant_id_reg;
   logic [IDW-1:0]   rr_ptr_reg;
   logic [3:0]       beat_cnt_reg;
   logic             busy_reg;

   logic             pick_any;
   logic [IDW-1:0]   pick_idx;
   logic             in_grant;
   logic             gnt_valid;
   logic             gnt_last;
   logic [3:0]       beat_next;
   logic             burst_full;
   logic [IDW-1:0]   rr_ptr_next;
   logic [DWIDTH-1:0] data_slice [NREQ];

   rr_picker #(.N(NREQ), .IDW(IDW)) u_picker (
      .req (req_valid),
      .ptr (rr_ptr_reg),
      .any (pick_any),
      .idx (pick_idx)
   );

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
         assign data_slice[gi] = req_data[gi*DWIDTH +: DWIDTH];
      end
   endgenerate

   assign in_grant    = (state_reg == GRANT);
   assign gnt_valid   = req_valid[grant_id_reg];
   assign gnt_last    = req_last[grant_id_reg];
   assign beat_next   = beat_cnt_reg + 4'd1;
   assign burst_full  = (beat_next == 4'(BURST));
   assign rr_ptr_next = (grant_id_reg == IDW'(NREQ - 1)) ? '0 : grant_id_reg + IDW'(1);

   // Reset gating keeps the handshake quiet even before the async clear settles.
   assign fifo_push = in_grant & gnt_valid & fifo_not_full & ~reset;
   assign fifo_din  = data_slice[grant_id_reg];
   assign grant_id  = grant_id_reg;
   assign busy      = busy_reg;

   always_comb begin
      req_ready = '0;
      if (in_grant && !reset) req_ready[grant_id_reg] = fifo_not_full;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         grant_id_reg <= '0;
         rr_ptr_reg   <= '0;
         beat_cnt_reg <= '0;
         busy_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pick_any) begin
                  grant_id_reg <= pick_idx;
                  beat_cnt_reg <= '0;
                  state_reg    <= GRANT;
                  busy_reg     <= 1'b1;
               end
            end
            GRANT: begin
               // A dropped valid ends the burst; a full FIFO merely stalls it.
               if (!gnt_valid) begin
                  state_reg  <= IDLE;
                  busy_reg   <= 1'b0;
                  rr_ptr_reg <= rr_ptr_next;
               end else if (fifo_not_full) begin
                  beat_cnt_reg <= beat_next;
                  if (gnt_last || burst_full) begin
                     state_reg  <= IDLE;
                     busy_reg   <= 1'b0;
                     rr_ptr_reg <= rr_ptr_next;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIFO_PUSH_ARB_STATS_EN
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
         logic [STAT_W-1:0] cnt_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_reg <= '0;
            end else if (fifo_push && grant_id_reg == IDW'(gi)) begin
               cnt_reg <= sat_inc(cnt_reg);
            end
         end
         assign stat_beats[gi*STAT_W +: STAT_W] = cnt_reg;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed testbench for fifo_push_arb; define FIFO_PUSH_ARB_STATS_EN to also
// exercise the stat counters.
module tb_fifo_push_arb;

   localparam int NREQ   = 4;
   localparam int DWIDTH = 8;
   localparam int BURST  = 4;
   localparam int IDW    = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_last;
   logic [NREQ*DWIDTH-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   fifo_not_full;
   logic                   fifo_push;
   logic [DWIDTH-1:0]      fifo_din;
   logic [IDW-1:0]         grant_id;
   logic                   busy;
`ifdef FIFO_PUSH_ARB_STATS_EN
   logic [NREQ*16-1:0]     stat_beats;
`endif

   fifo_push_arb #(.NREQ(NREQ), .DWIDTH(DWIDTH), .BURST(BURST)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_last      (req_last),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .fifo_not_full (fifo_not_full),
      .fifo_push     (fifo_push),
      .fifo_din      (fifo_din),
      .grant_id      (grant_id),
      .busy          (busy)
`ifdef FIFO_PUSH_ARB_STATS_EN
      ,
      .stat_beats    (stat_beats)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Requester model: beats still to offer, last-flag policy (0 never,
   // 1 on final beat, 2 every beat) and beats accepted so far.
   int   remain   [NREQ];
   int   last_cfg [NREQ];
   int   sent     [NREQ];
   int   pushes;
   int   busy_cycles;
   int   idle_run;
   int   grants [$];
   int   gaps   [$];
   logic prev_busy;
   bit   quiet;

   task automatic clear_model();
      for (int i = 0; i < NREQ; i++) begin
         remain[i]   = 0;
         last_cfg[i] = 0;
         sent[i]     = 0;
      end
      pushes      = 0;
      busy_cycles = 0;
      idle_run    = 0;
      prev_busy   = 1'b0;
      grants.delete();
      gaps.delete();
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = (remain[i] > 0);
         req_last[i]  = (last_cfg[i] == 2) || (last_cfg[i] == 1 && remain[i] == 1);
         req_data[i*DWIDTH +: DWIDTH] = {4'(i), 4'(sent[i])};
      end
   endtask

   task automatic sample_outputs();
      logic [DWIDTH-1:0] exp_din;
      checks++;
      if (fifo_push && !fifo_not_full)
         $display("FAIL push_while_full: fifo_push=%0b fifo_not_full=%0b", fifo_push, fifo_not_full);
      else passed++;
      checks++;
      if (!busy && req_ready !== '0)
         $display("FAIL ready_in_idle: req_ready=%b required 0000", req_ready);
      else passed++;
      if (fifo_push) begin
         exp_din = {4'(grant_id), 4'(sent[grant_id])};
         checks++;
         if (fifo_din !== exp_din)
            $display("FAIL push_data: fifo_din=%h required %h", fifo_din, exp_din);
         else passed++;
         if (!quiet) $display("push req=%0d data=%h beat=%0d", grant_id, fifo_din, sent[grant_id]);
         sent[grant_id]++;
         remain[grant_id]--;
         pushes++;
      end
      if (busy && !prev_busy) begin
         grants.push_back(int'(grant_id));
         gaps.push_back(idle_run);
      end
      if (busy) begin
         idle_run = 0;
         busy_cycles++;
      end else begin
         idle_run++;
      end
      prev_busy = busy;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      apply_inputs();
      #1;
      sample_outputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_model();
      fifo_not_full = 1'b1;
      apply_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_model();
      fifo_not_full = 1'b1;
      for (int i = 0; i < NREQ; i++) remain[i] = 3;
      apply_inputs();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: busy=%0b required 0", busy); else passed++;
      checks++; if (grant_id !== '0) $display("FAIL reset_grant_id: grant_id=%0d required 0", grant_id); else passed++;
      checks++; if (req_ready !== '0) $display("FAIL reset_ready: req_ready=%b required 0000", req_ready); else passed++;
      checks++; if (fifo_push !== 1'b0) $display("FAIL reset_push: fifo_push=%0b required 0", fifo_push); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_two_beats();
      do_reset();
      remain[0]   = 2;
      last_cfg[0] = 1;
      repeat (8) cycle();
      checks++; if (sent[0] !== 2) $display("FAIL two_beats_count: pushes=%0d required 2", sent[0]); else passed++;
      checks++; if (grants.size() !== 1) $display("FAIL two_beats_grants: grants=%0d required 1", grants.size()); else passed++;
      checks++; if ((grants.size() > 0 ? grants[0] : -1) !== 0) $display("FAIL two_beats_id: grant_id=%0d required 0", (grants.size() > 0 ? grants[0] : -1)); else passed++;
      checks++; if (busy_cycles !== 2) $display("FAIL two_beats_busy: busy cycles=%0d required 2", busy_cycles); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL two_beats_idle: busy=%0b required 0", busy); else passed++;
   endtask

   task automatic test_round_robin();
      int exp_order [5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         remain[i]   = 100;
         last_cfg[i] = 2;
      end
      for (int n = 0; n < 40 && grants.size() < 5; n++) cycle();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ((k < grants.size() ? grants[k] : -1) !== exp_order[k])
            $display("FAIL rr_order[%0d]: grant_id=%0d required %0d", k, (k < grants.size() ? grants[k] : -1), exp_order[k]);
         else passed++;
      end
      for (int k = 1; k < 5; k++) begin
         checks++;
         if ((k < gaps.size() ? gaps[k] : -1) !== 1)
            $display("FAIL rr_gap[%0d]: idle cycles=%0d required 1", k, (k < gaps.size() ? gaps[k] : -1));
         else passed++;
      end
   endtask

   task automatic test_burst_limit();
      do_reset();
      remain[2] = 20;
      for (int n = 0; n < 20; n++) begin
         cycle();
         if (pushes > 0 && !busy) break;
      end
      checks++; if (pushes !== BURST) $display("FAIL burst_count: pushes=%0d required %0d", pushes, BURST); else passed++;
      checks++; if (busy_cycles !== BURST) $display("FAIL burst_busy: busy cycles=%0d required %0d", busy_cycles, BURST); else passed++;
      // Everyone now competes: the pointer must have moved past requester 2.
      remain[0] = 1; remain[1] = 1; remain[3] = 1;
      last_cfg[0] = 1; last_cfg[1] = 1; last_cfg[3] = 1;
      apply_inputs();
      for (int n = 0; n < 20 && grants.size() < 2; n++) cycle();
      checks++; if ((grants.size() > 1 ? grants[1] : -1) !== 3) $display("FAIL burst_rr_ptr: next grant=%0d required 3", (grants.size() > 1 ? grants[1] : -1)); else passed++;
      checks++; if ((gaps.size() > 1 ? gaps[1] : -1) !== 1) $display("FAIL burst_gap: idle cycles=%0d required 1", (gaps.size() > 1 ? gaps[1] : -1)); else passed++;
   endtask

   task automatic test_stall();
      int stall_left = 5;
      do_reset();
      remain[1] = 20;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk);
         #1;
         fifo_not_full = !(pushes == 2 && stall_left > 0);
         apply_inputs();
         #1;
         if (!fifo_not_full) begin
            checks++; if (fifo_push !== 1'b0) $display("FAIL stall_push: fifo_push=%0b required 0", fifo_push); else passed++;
            checks++; if (busy !== 1'b1 || grant_id !== 2'd1) $display("FAIL stall_hold: busy=%0b grant_id=%0d required 1/1", busy, grant_id); else passed++;
            stall_left--;
         end
         sample_outputs();
         if (pushes > 0 && !busy) break;
      end
      fifo_not_full = 1'b1;
      checks++; if (stall_left !== 0) $display("FAIL stall_cycles: remaining stall=%0d required 0", stall_left); else passed++;
      checks++; if (pushes !== BURST) $display("FAIL stall_total: pushes=%0d required %0d", pushes, BURST); else passed++;
      checks++; if (busy_cycles !== BURST + 5) $display("FAIL stall_busy: busy cycles=%0d required %0d", busy_cycles, BURST + 5); else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      remain[0] = 20;
      for (int n = 0; n < 10 && pushes < 1; n++) cycle();
      @(posedge clk);
      #1;
      reset = 1'b1;
      apply_inputs();
      #1;
      checks++; if (fifo_push !== 1'b0) $display("FAIL midreset_push: fifo_push=%0b required 0", fifo_push); else passed++;
      checks++; if (req_ready !== '0) $display("FAIL midreset_ready: req_ready=%b required 0000", req_ready); else passed++;
      repeat (2) begin
         @(negedge clk);
         checks++; if (fifo_push !== 1'b0) $display("FAIL midreset_hold: fifo_push=%0b required 0", fifo_push); else passed++;
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) $display("FAIL midreset_idle: busy=%0b required 0", busy); else passed++;
      for (int i = 0; i < NREQ; i++) begin
         remain[i]   = 1;
         last_cfg[i] = 1;
      end
      grants.delete();
      gaps.delete();
      prev_busy = 1'b0;
      apply_inputs();
      for (int n = 0; n < 10 && grants.size() < 1; n++) cycle();
      checks++; if ((grants.size() > 0 ? grants[0] : -1) !== 0) $display("FAIL midreset_rr_ptr: first grant=%0d required 0", (grants.size() > 0 ? grants[0] : -1)); else passed++;
   endtask

`ifdef FIFO_PUSH_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      quiet     = 1'b1;
      remain[1] = 70000;
      for (int n = 0; n < 90000 && sent[1] < 70000; n++) cycle();
      repeat (2) cycle();
      quiet = 1'b0;
      checks++; if (sent[1] !== 70000) $display("FAIL stats_beats_sent: beats=%0d required 70000", sent[1]); else passed++;
      checks++; if (stat_beats[16 +: 16] !== 16'hFFFF) $display("FAIL stats_saturate: stat=%h required ffff", stat_beats[16 +: 16]); else passed++;
      checks++; if (stat_beats[0 +: 16] !== 16'h0000) $display("FAIL stats_idle_req: stat=%h required 0000", stat_beats[0 +: 16]); else passed++;
   endtask
`endif

   initial begin
      reset         = 1'b1;
      quiet         = 1'b0;
      fifo_not_full = 1'b1;
      req_valid     = '0;
      req_last      = '0;
      req_data      = '0;
      test_reset();
      test_two_beats();
      test_round_robin();
      test_burst_limit();
      test_stall();
      test_reset_mid();
`ifdef FIFO_PUSH_ARB_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter DWIDTH, default 8, giving the data width in bits.
REQ-003 The block SHALL have parameter BURST, default 4, giving the maximum beats per grant (1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, NREQ bits: per-requester data valid.
REQ-007 The block SHALL have port req_last, input, NREQ bits: per-requester last beat of a burst.
REQ-008 The block SHALL have port req_data, input, NREQ*DWIDTH bits: requester i data in slice [i*DWIDTH +: DWIDTH].
REQ-009 The block SHALL have port req_ready, output, NREQ bits: per-requester beat accepted this cycle.
REQ-010 The block SHALL have port fifo_not_full, input, 1 bit: downstream FIFO can take a push this cycle.
REQ-011 The block SHALL have port fifo_push, output, 1 bit: push strobe to the downstream FIFO.
REQ-012 The block SHALL have port fifo_din, output, DWIDTH bits: push data to the downstream FIFO.
REQ-013 The block SHALL have port grant_id, output, clog2(NREQ) bits: currently granted requester.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in state GRANT.

Function
REQ-015 FSM states SHALL be IDLE and GRANT.
REQ-016 In IDLE with any req_valid high, the block SHALL register as grant_id the first valid requester at or after rr_ptr (wrapping NREQ-1 to 0), clear beat_cnt and enter GRANT next cycle.
REQ-017 In IDLE with no req_valid high, the block SHALL stay in IDLE with all req_ready, fifo_push and busy low.
REQ-018 In GRANT, req_ready[grant_id] SHALL equal fifo_not_full, and all other req_ready bits SHALL be 0.
REQ-019 In GRANT, fifo_push SHALL equal req_valid[grant_id] & fifo_not_full, combinationally in the same cycle.
REQ-020 fifo_din SHALL always present the req_data slice of grant_id.
REQ-021 Each accepted beat SHALL increment beat_cnt.
REQ-022 GRANT SHALL exit to IDLE after the cycle in which any one of these holds: the accepted beat has req_last high; the accepted beat makes beat_cnt reach BURST; req_valid[grant_id] is low.
REQ-023 On GRANT exit, rr_ptr SHALL become grant_id+1 modulo NREQ.
REQ-024 A stall (valid high, fifo_not_full low) SHALL hold GRANT, beat_cnt and grant_id unchanged and SHALL NOT end the burst.
REQ-025 Arbitration latency SHALL be exactly one IDLE cycle between consecutive grants, with no back-to-back grant.
REQ-026 The block SHALL never assert fifo_push while fifo_not_full is low.

Reset
REQ-027 On reset, state SHALL be IDLE, and rr_ptr, grant_id, beat_cnt and busy SHALL be 0.
REQ-028 req_ready and fifo_push SHALL be 0 while reset is asserted.
REQ-029 Reset asserted mid-burst SHALL abandon the burst without any further push.

Configuration
REQ-030 With macro FIFO_PUSH_ARB_STATS_EN defined, the block SHALL add output stat_beats, NREQ*16 bits, holding per-requester 16-bit saturating counters of accepted beats.
REQ-031 With FIFO_PUSH_ARB_STATS_EN defined, the stat_beats counters SHALL reset to 0 and hold at 16'hFFFF once saturated.
REQ-032 Without FIFO_PUSH_ARB_STATS_EN, the stat_beats port and its counters SHALL be absent, with all other behaviour identical.

Structure
REQ-033 Package fifo_arb_pkg SHALL hold the FSM state encoding (IDLE=0, GRANT=1) and the stat counter width constant (16).
REQ-034 Round-robin selection SHALL be a combinational sub-module rr_picker with inputs req and ptr and outputs any and idx.

Verification
REQ-035 Reset, then req_valid=4'b0001 with req_last high on the 2nd beat and fifo_not_full=1 -> grant_id=0, exactly 2 pushes, then IDLE.
REQ-036 All 4 requesters valid continuously, each with single-beat last bursts -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-037 Requester 2 valid with req_last never asserted, BURST=4 -> exactly 4 pushes, then IDLE, then rr_ptr=3.
REQ-038 fifo_not_full held low for 5 cycles mid-burst -> fifo_push=0 for those cycles, burst resumes, and total beats still equal 4.
REQ-039 reset asserted after beat 1 of a burst -> fifo_push=0 immediately, and on release state=IDLE, rr_ptr=0.
REQ-040 With FIFO_PUSH_ARB_STATS_EN, 70000 beats on requester 1 -> stat_beats slice 1 = 16'hFFFF.
